// File: rtl/jogada_display_ctrl_if.sv
// Move-request handshake and display outputs shared by the two move sources and the controller.
// The master side presents moves; the slave side is the display controller.
interface jogada_display_ctrl_if;
  logic [1:0]  req_valid;
  logic [11:0] req_jogada0;
  logic [11:0] req_jogada1;
  logic [1:0]  req_ready;
  logic [15:0] hexa;
  logic        busy;
  logic        owner;
  logic        done;

  modport master (
    output req_valid, req_jogada0, req_jogada1,
    input  req_ready, hexa, busy, owner, done
  );

  modport slave (
    input  req_valid, req_jogada0, req_jogada1,
    output req_ready, hexa, busy, owner, done
  );
endinterface

// File: rtl/jogada_display_ctrl.sv
// Arbitrates two move sources onto the four coordinate digits, blinks the accepted move,
// holds it steady, then pulses done and returns to idle.
module jogada_display_ctrl #(
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter int unsigned BLINK_COUNT  = 4,
  parameter int unsigned HOLD_CYCLES  = 50_000_000
) (
  input logic                  clock,
  input logic                  reset,
  jogada_display_ctrl_if.slave bus
);

  localparam int unsigned CycMax = (BLINK_CYCLES > HOLD_CYCLES) ? BLINK_CYCLES : HOLD_CYCLES;
  localparam int unsigned CycW   = $clog2(CycMax + 1);
  localparam int unsigned PhW    = $clog2(2 * BLINK_COUNT + 1);

  localparam logic [CycW-1:0] BlinkLast = CycW'(BLINK_CYCLES - 1);
  localparam logic [CycW-1:0] HoldLast  = CycW'(HOLD_CYCLES - 1);
  localparam logic [PhW-1:0]  PhaseLast = PhW'(2 * BLINK_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StBlink, StHold, StDone} state_e;

  state_e          state_q, state_d;
  logic [11:0]     move_q, move_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic            shown_q, shown_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [PhW-1:0]  phase_q, phase_d;

  logic            grant_src;
  logic [15:0]     move_hex;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      move_q  <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      shown_q <= 1'b0;
      cyc_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      shown_q <= shown_d;
      cyc_q   <= cyc_d;
      phase_q <= phase_d;
    end
  end

  // Contention goes to prio; otherwise whichever source is asking.
  assign grant_src = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];

  assign move_hex = {1'b0, move_q[11:9], 1'b0, move_q[8:6], 1'b0, move_q[5:3], 1'b0, move_q[2:0]};

  always_comb begin
    state_d       = state_q;
    move_d        = move_q;
    owner_d       = owner_q;
    prio_d        = prio_q;
    shown_d       = shown_q;
    cyc_d         = cyc_q;
    phase_d       = phase_q;
    bus.req_ready = 2'b00;
    bus.hexa      = move_hex;

    unique case (state_q)
      StIdle: begin
        bus.hexa = shown_q ? move_hex : 16'hFFFF;
        // Grant is suppressed while reset is asserted.
        if (reset && (bus.req_valid != 2'b00)) begin
          bus.req_ready = grant_src ? 2'b10 : 2'b01;
          move_d        = grant_src ? bus.req_jogada1 : bus.req_jogada0;
          owner_d       = grant_src;
          prio_d        = ~grant_src;
          shown_d       = 1'b1;
          cyc_d         = '0;
          phase_d       = '0;
          state_d       = StBlink;
        end
      end
      StBlink: begin
        bus.hexa = phase_q[0] ? 16'hFFFF : move_hex;
        if (cyc_q == BlinkLast) begin
          cyc_d = '0;
          if (phase_q == PhaseLast) begin
            state_d = StHold;
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StHold: begin
        if (cyc_q == HoldLast) begin
          cyc_d   = '0;
          state_d = StDone;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.owner = owner_q;
  assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_jogada_display_ctrl.sv
// Directed bench for jogada_display_ctrl with short blink/hold timing.
// Each accepted move is followed cycle by cycle against a hand-derived display schedule.
module tb_jogada_display_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  jogada_display_ctrl_if u_if ();

  jogada_display_ctrl #(
    .BLINK_CYCLES(2),
    .BLINK_COUNT (2),
    .HOLD_CYCLES (8)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Entered in the grant cycle c0; leaves in the first idle cycle c18.
  task automatic run_seq(input logic [15:0] mv, input logic own, input logic [1:0] nv);
    logic [15:0] e;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 1) begin
        u_if.req_valid = nv;
        #1;
      end
      e = ((c == 3) || (c == 4) || (c == 7) || (c == 8)) ? 16'hFFFF : mv;
      check($sformatf("hexa c%0d", c), u_if.hexa, e);
      check($sformatf("busy c%0d", c), {15'd0, u_if.busy}, 16'd1);
      check($sformatf("done c%0d", c), {15'd0, u_if.done}, (c == 17) ? 16'd1 : 16'd0);
      check($sformatf("ready c%0d", c), {14'd0, u_if.req_ready}, 16'd0);
      check($sformatf("owner c%0d", c), {15'd0, u_if.owner}, {15'd0, own});
    end
    step();
    #1;
    check("hexa idle", u_if.hexa, mv);
    check("busy idle", {15'd0, u_if.busy}, 16'd0);
    check("done idle", {15'd0, u_if.done}, 16'd0);
  endtask

  initial begin
    n_checks           = 0;
    n_pass             = 0;
    reset              = 1'b0;
    u_if.req_valid     = 2'b00;
    u_if.req_jogada0   = 12'o0000;
    u_if.req_jogada1   = 12'o0000;
    repeat (3) step();
    check("reset hexa", u_if.hexa, 16'hFFFF);
    check("reset busy", {15'd0, u_if.busy}, 16'd0);
    check("reset owner", {15'd0, u_if.owner}, 16'd0);
    reset = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle hexa", u_if.hexa, 16'hFFFF);
      check("idle busy", {15'd0, u_if.busy}, 16'd0);
      check("idle ready", {14'd0, u_if.req_ready}, 16'd0);
    end

    // Single src0 move
    u_if.req_jogada0 = 12'o1234;
    u_if.req_valid   = 2'b01;
    #1;
    check("t2 ready", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h1234, 1'b0, 2'b00);

    // Contention after reset: src0 first, held src1 next, then alternation back to src0
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    u_if.req_jogada0 = 12'o1111;
    u_if.req_jogada1 = 12'o2222;
    u_if.req_valid   = 2'b11;
    #1;
    check("t3 ready a", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h1111, 1'b0, 2'b10);
    check("t3 ready b", {14'd0, u_if.req_ready}, 16'h0002);
    run_seq(16'h2222, 1'b1, 2'b00);
    u_if.req_jogada0 = 12'o4444;
    u_if.req_jogada1 = 12'o5555;
    u_if.req_valid   = 2'b11;
    #1;
    check("t3 ready c", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h4444, 1'b0, 2'b00);

    // src1 arrives mid-blink and must wait
    u_if.req_jogada0 = 12'o3456;
    u_if.req_jogada1 = 12'o7777;
    u_if.req_valid   = 2'b01;
    #1;
    check("t4 ready a", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h3456, 1'b0, 2'b10);
    check("t4 ready b", {14'd0, u_if.req_ready}, 16'h0002);
    run_seq(16'h7777, 1'b1, 2'b00);

    // Reset mid-sequence aborts; prio returns to src0
    u_if.req_jogada0 = 12'o1234;
    u_if.req_jogada1 = 12'o6543;
    u_if.req_valid   = 2'b01;
    #1;
    check("t5 ready a", {14'd0, u_if.req_ready}, 16'h0001);
    step();
    u_if.req_valid = 2'b11;
    repeat (5) step();
    check("t5 hexa c6", u_if.hexa, 16'h1234);
    reset = 1'b0;
    #1;
    check("t5 ready rst", {14'd0, u_if.req_ready}, 16'd0);
    step();
    check("t5 hexa abort", u_if.hexa, 16'hFFFF);
    check("t5 busy abort", {15'd0, u_if.busy}, 16'd0);
    check("t5 done abort", {15'd0, u_if.done}, 16'd0);
    check("t5 ready in rst", {14'd0, u_if.req_ready}, 16'd0);
    reset = 1'b1;
    #1;
    check("t5 ready regrant", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h1234, 1'b0, 2'b00);

    // Max coordinate mixed with zero
    u_if.req_jogada0 = 12'o7070;
    u_if.req_valid   = 2'b01;
    #1;
    check("t6 ready", {14'd0, u_if.req_ready}, 16'h0001);
    run_seq(16'h7070, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
